muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Holds the FSM state encoding and the Funct3 opcode map.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CW    = $clog2(ITERS);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Operand bits are picked by the iteration counter; acc holds the state.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [4:0]        count,
  output logic [2*XLEN-1:0] acc_next
);
  import muldiv_pkg::*;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            ge;

  // Multiply walks b LSB-first; divide feeds a MSB-first into the remainder.
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]}
        + (b[count] ? {1'b0, a} : '0);
    shifted = {acc[2*XLEN-1:XLEN], a[~count]};
    diff = {1'b0, shifted} - {2'b00, b};
    ge = ~diff[XLEN+1];
    if (is_div) begin
      acc_next = {
        ge ? diff[XLEN-1:0] : shifted[XLEN-1:0],
        acc[XLEN-2:0],
        ge
      };
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit with pipeline stall/flush.
// Signed ops run on magnitudes and are sign-corrected in FIX.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic            Stall,
  output logic [XLEN-1:0] Result
);
  import muldiv_pkg::*;

  localparam int W2 = 2 * XLEN;

  state_t state;
  state_t state_nx;

  logic [2:0]      fn;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            res_neg;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   acc_nx;
  logic [CW-1:0]   count;

  logic            is_div;
  logic            is_rem;
  logic            sgn_a;
  logic            sgn_b;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            ovf;
  logic            early;
  logic [XLEN-1:0] early_val;
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] fix_val;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .a       (a_q),
    .b       (b_q),
    .count   (count),
    .acc_next(acc_nx)
  );

  always_comb begin
    is_div = fn[2];
    is_rem = fn[2] & fn[1];
    sgn_a = (fn == F3_MULH) | (fn == F3_MULHSU)
          | (fn == F3_DIV) | (fn == F3_REM);
    sgn_b = (fn == F3_MULH) | (fn == F3_DIV)
          | (fn == F3_REM);
    neg_a = sgn_a & a_q[XLEN-1];
    neg_b = sgn_b & b_q[XLEN-1];
    abs_a = neg_a ? -a_q : a_q;
    abs_b = neg_b ? -b_q : b_q;
    div_zero = is_div & (b_q == '0);
    ovf = is_div & sgn_b
        & (a_q == {1'b1, {(XLEN-1){1'b0}}})
        & (b_q == '1);
    early = div_zero | ovf;
    if (div_zero) begin
      early_val = is_rem ? a_q : '1;
    end else begin
      early_val = is_rem ? '0
                : {1'b1, {(XLEN-1){1'b0}}};
    end
    prod = res_neg ? -acc : acc;
    quot = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = res_neg ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
    fix_val = quot;
    unique case (1'b1)
      (fn == F3_MUL):          fix_val = prod[XLEN-1:0];
      (!is_div && fn != F3_MUL): fix_val = prod[W2-1:XLEN];
      (is_div && !is_rem):     fix_val = quot;
      (is_rem):                fix_val = rem;
      default:                 fix_val = quot;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (Start && !Flush) state_nx = PREP;
      PREP: begin
        if (Flush) state_nx = IDLE;
        else if (early) state_nx = DONE;
        else state_nx = CALC;
      end
      CALC: begin
        if (Flush) state_nx = IDLE;
        else if (count == CW'(ITERS - 1)) state_nx = FIX;
      end
      FIX:  state_nx = Flush ? IDLE : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fn      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_neg <= 1'b0;
      acc     <= '0;
      count   <= '0;
      Result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start && !Flush) begin
            fn  <= Funct3;
            a_q <= SrcA;
            b_q <= SrcB;
          end
        end
        PREP: begin
          a_q     <= abs_a;
          b_q     <= abs_b;
          res_neg <= is_rem ? neg_a : (neg_a ^ neg_b);
          acc     <= '0;
          count   <= '0;
          if (!Flush && early) Result <= early_val;
        end
        CALC: begin
          acc   <= acc_nx;
          count <= count + 1'b1;
        end
        FIX: if (!Flush) Result <= fix_val;
        default: ;
      endcase
    end
  end

  // Reset gating keeps Stall low even if Start is held during reset.
  assign Busy  = (state == PREP) | (state == CALC)
               | (state == FIX);
  assign Done  = (state == DONE);
  assign Stall = ~reset
               & (((state == IDLE) & Start) | Busy);

endmodule
